merger_node_p: RTL and testbench
================================

Name: merger_node_p

Overview:
- Parametrised 2-to-1 merge node for the merge tree.
- Consumes two sorted runs, each arriving as P-record batches from first-word-fall-through (FWFT) input FIFOs, and emits one sorted run as P-record batches into an output FIFO.
- Adds what the fixed 16-wide node lacks:
  - reset;
  - generic P;
  - explicit run boundaries (per-input last flag), with drain and flush of the held batch, and an output last flag.
- Instantiated per tree node; a tree generator chains nodes through FIFOs.

Parameters:
P, 16, records per batch; power of 2, 2..32
DATA_WIDTH, 32, bits per record
KEY_WIDTH, 32, sort key width; key = record[DATA_WIDTH-1 -: KEY_WIDTH]; KEY_WIDTH <= DATA_WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_fifo_0  in  P*DATA_WIDTH  head batch of input 0; record k at bits [k*DATA_WIDTH +: DATA_WIDTH], ascending in k
i_fifo_0_empty  in  1  input 0 FIFO empty
i_fifo_0_last  in  1  head batch of input 0 is the final batch of its run
i_fifo_1  in  P*DATA_WIDTH  head batch of input 1, same layout
i_fifo_1_empty  in  1  input 1 FIFO empty
i_fifo_1_last  in  1  head batch of input 1 is the final batch of its run
i_fifo_out_ready  in  1  output FIFO can accept 2 more writes (almost-full inverted, slack >= 1)
o_fifo_0_read  out  1  pop input 0 (combinational, FWFT)
o_fifo_1_read  out  1  pop input 1
o_out_fifo_write  out  1  registered write strobe
o_data  out  P*DATA_WIDTH  registered output batch, ascending
o_out_last  out  1  registered; final batch of merged run

Behaviour:
- Reset: all outputs 0; state IDLE; held register (P records) cleared.
- Compare: unsigned key compare of record 0 of each head; tie selects input 0.
- Merge op: bitonic merge of the selected batch with the held register; lower P records go to o_data, upper P go to the held register. Combinational network; o_data/o_out_fifo_write are registered, so the write appears 1 cycle after the pop.
- Stall: a cycle fires only if i_fifo_out_ready=1 and every input required by the state is non-empty. Otherwise no read and o_out_fifo_write=0 next cycle; held state unchanged.
- States:
  - IDLE:
    - Needs both inputs non-empty.
    - Pop the smaller head into the held register. No output write.
    - If the popped batch has last=1: go to DRAIN_1 (popped input 0) or DRAIN_0 (popped input 1). Else go to MERGE.
  - MERGE:
    - Needs both inputs non-empty.
    - Pop the smaller head and merge-op it.
    - If the popped batch has last=1: go to DRAIN of the other input.
  - DRAIN_0 / DRAIN_1:
    - Needs only that input non-empty; the other input's read stays 0 even if non-empty (its next run waits).
    - Pop and merge-op.
    - If last=1: go to FLUSH.
  - FLUSH:
    - Needs only i_fifo_out_ready.
    - Write the held register with o_out_last=1, clear it, go to IDLE.
- Run of N+M input batches yields exactly N+M output batches; only the final one has o_out_last=1.
- At most one of o_fifo_0_read / o_fifo_1_read is high in any cycle.
- Reset mid-run: async clear; partial run discarded; no write in the first cycle after deassert.

Decomposition:
- Package merger_pkg holds:
  - batch width function P*DATA_WIDTH;
  - key extract function;
  - state enum {IDLE, MERGE, DRAIN_0, DRAIN_1, FLUSH}.
- One sub-module: bitonic_half_merger_p. Parameters P, DATA_WIDTH, KEY_WIDTH. Takes two ascending P-batches, returns sorted lower P and upper P. Purely combinational, log2(2P) compare-exchange stages.

Test Plan:
- P=4 basic merge:
  - Stimulus: input 0 = [1,3,5,7],[9,11,13,15]L; input 1 = [2,4,6,8],[10,12,14,16]L.
  - Required output: [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16]L.
  - Reads, in order: 0, 1, 0, 1.
- Tie:
  - Stimulus: both heads [5,5,5,5] with last=1.
  - Required: input 0 popped first.
  - Required output: [5,5,5,5],[5,5,5,5]L.
- Backpressure:
  - Stimulus: the basic-merge stream with i_fifo_out_ready toggled 1,0,0,1,...
  - Required: no read or write in stalled cycles; output sequence identical to the basic merge.
- Empty gaps:
  - Stimulus: input 1 empty for 3 cycles during MERGE.
  - Required: no reads and no writes during the gap; correct resumption after it.
  - Stimulus: input 0 empty during DRAIN_1.
  - Required: no effect; DRAIN_1 continues.
- Single-batch runs and back-to-back runs:
  - Stimulus: [1,2,3,4]L vs [0,9,9,9]L, then a second run pair already queued.
  - Required: output [0,1,2,3],[4,9,9,9]L, then the second run starts from IDLE.
- Async reset:
  - Stimulus: assert i_rst mid-DRAIN, off clock edge.
  - Required: outputs 0 immediately; a new run then merges correctly.

Source files
------------

// File: rtl/merger_pkg.sv
// Shared types and helpers for the parametrised merge-tree node.
// Keys are compared as the top KEY_WIDTH bits of each record.
package merger_pkg;

  localparam int MAX_REC_W = 1024;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN_0,
    DRAIN_1,
    FLUSH
  } state_t;

  function automatic int batch_width(input int p, input int data_width);
    return p * data_width;
  endfunction

  // Record is zero-extended to MAX_REC_W, so shifting off the low bits leaves only the key.
  function automatic logic [MAX_REC_W-1:0] key_of(input logic [MAX_REC_W-1:0] rec,
                                                  input int data_width,
                                                  input int key_width);
    return rec >> (data_width - key_width);
  endfunction

endpackage

// File: rtl/merger_node_p_bitonic.sv
// Combinational bitonic half merger: two ascending P-batches in, sorted lower
// and upper P records out, using log2(2P) compare-exchange stages.
module bitonic_half_merger_p
  import merger_pkg::*;
#(
  parameter int P          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32
) (
  input  logic [P*DATA_WIDTH-1:0] i_a,
  input  logic [P*DATA_WIDTH-1:0] i_b,
  output logic [P*DATA_WIDTH-1:0] o_lo,
  output logic [P*DATA_WIDTH-1:0] o_hi
);

  localparam int N      = 2 * P;
  localparam int STAGES = $clog2(N);
  localparam int DW     = DATA_WIDTH;

  logic [N*DW-1:0] seq_init;

  genvar gi, gs;

  // a ascending followed by b reversed forms one bitonic sequence
  generate
    for (gi = 0; gi < P; gi++) begin : g_init
      assign seq_init[gi*DW +: DW]     = i_a[gi*DW +: DW];
      assign seq_init[(P+gi)*DW +: DW] = i_b[(P-1-gi)*DW +: DW];
    end

    for (gs = 0; gs < STAGES; gs++) begin : g_stage
      localparam int D = P >> gs;
      logic [N*DW-1:0] vin;
      logic [N*DW-1:0] vout;

      if (gs == 0) begin : g_first
        assign vin = seq_init;
      end else begin : g_next
        assign vin = g_stage[gs-1].vout;
      end

      for (gi = 0; gi < N; gi++) begin : g_ce
        if ((gi & D) == 0) begin : g_pair
          logic swap;
          assign swap = key_of(MAX_REC_W'(vin[(gi+D)*DW +: DW]), DATA_WIDTH, KEY_WIDTH)
                      < key_of(MAX_REC_W'(vin[gi*DW +: DW]), DATA_WIDTH, KEY_WIDTH);
          assign vout[gi*DW +: DW]     = swap ? vin[(gi+D)*DW +: DW] : vin[gi*DW +: DW];
          assign vout[(gi+D)*DW +: DW] = swap ? vin[gi*DW +: DW] : vin[(gi+D)*DW +: DW];
        end
      end
    end
  endgenerate

  assign o_lo = g_stage[STAGES-1].vout[P*DW-1:0];
  assign o_hi = g_stage[STAGES-1].vout[N*DW-1:P*DW];

endmodule

// File: rtl/merger_node_p.sv
// 2-to-1 merge node: merges two sorted runs of P-record batches from FWFT
// FIFOs into one sorted run, with run boundaries and a final flush.
module merger_node_p
  import merger_pkg::*;
#(
  parameter int P          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P*DATA_WIDTH-1:0] i_fifo_0,
  input  logic                    i_fifo_0_empty,
  input  logic                    i_fifo_0_last,
  input  logic [P*DATA_WIDTH-1:0] i_fifo_1,
  input  logic                    i_fifo_1_empty,
  input  logic                    i_fifo_1_last,
  input  logic                    i_fifo_out_ready,
  output logic                    o_fifo_0_read,
  output logic                    o_fifo_1_read,
  output logic                    o_out_fifo_write,
  output logic [P*DATA_WIDTH-1:0] o_data,
  output logic                    o_out_last
);

  localparam int BW = batch_width(P, DATA_WIDTH);

  state_t          state_q, state_d;
  logic [BW-1:0]   held_q, held_d;
  logic [BW-1:0]   data_q, data_d;
  logic            write_q, write_d;
  logic            last_q, last_d;

  logic            pick_1, sel_1, sel_last, need_ok, fire;
  logic [BW-1:0]   sel_batch, merged_lo, merged_hi;

  // Strict less-than so a tie picks input 0
  assign pick_1 = key_of(MAX_REC_W'(i_fifo_1[DATA_WIDTH-1:0]), DATA_WIDTH, KEY_WIDTH)
                < key_of(MAX_REC_W'(i_fifo_0[DATA_WIDTH-1:0]), DATA_WIDTH, KEY_WIDTH);

  assign sel_1     = (state_q == DRAIN_1) || (((state_q == IDLE) || (state_q == MERGE)) && pick_1);
  assign sel_batch = sel_1 ? i_fifo_1 : i_fifo_0;
  assign sel_last  = sel_1 ? i_fifo_1_last : i_fifo_0_last;

  bitonic_half_merger_p #(
    .P         (P),
    .DATA_WIDTH(DATA_WIDTH),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_merge (
    .i_a (held_q),
    .i_b (sel_batch),
    .o_lo(merged_lo),
    .o_hi(merged_hi)
  );

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    data_d        = data_q;
    write_d       = 1'b0;
    last_d        = 1'b0;
    o_fifo_0_read = 1'b0;
    o_fifo_1_read = 1'b0;

    case (state_q)
      IDLE, MERGE: need_ok = !i_fifo_0_empty && !i_fifo_1_empty;
      DRAIN_0:     need_ok = !i_fifo_0_empty;
      DRAIN_1:     need_ok = !i_fifo_1_empty;
      FLUSH:       need_ok = 1'b1;
      default:     need_ok = 1'b0;
    endcase
    fire = need_ok && i_fifo_out_ready;

    if (fire) begin
      if (state_q != FLUSH) begin
        o_fifo_0_read = !sel_1;
        o_fifo_1_read = sel_1;
      end
      case (state_q)
        IDLE: begin
          held_d  = sel_batch;
          state_d = !sel_last ? MERGE : (sel_1 ? DRAIN_0 : DRAIN_1);
        end
        MERGE: begin
          data_d  = merged_lo;
          held_d  = merged_hi;
          write_d = 1'b1;
          if (sel_last) state_d = sel_1 ? DRAIN_0 : DRAIN_1;
        end
        DRAIN_0, DRAIN_1: begin
          data_d  = merged_lo;
          held_d  = merged_hi;
          write_d = 1'b1;
          if (sel_last) state_d = FLUSH;
        end
        FLUSH: begin
          data_d  = held_q;
          write_d = 1'b1;
          last_d  = 1'b1;
          held_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      data_q  <= data_d;
      write_q <= write_d;
      last_q  <= last_d;
    end
  end

  assign o_out_fifo_write = write_q;
  assign o_data           = data_q;
  assign o_out_last       = last_q;

endmodule

// File: tb/tb_merger_node_p.sv
// Bench for merger_node_p (P=4): table of single-batch pairs, hand-written
// corner sequences, and randomized back-to-back runs against a sort model.
module tb_merger_node_p;

  localparam int P  = 4;
  localparam int DW = 32;
  localparam int BW = P * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] i_fifo_0, i_fifo_1;
  logic          i_fifo_0_empty, i_fifo_1_empty, i_fifo_0_last, i_fifo_1_last;
  logic          i_fifo_out_ready;
  logic          o_fifo_0_read, o_fifo_1_read, o_out_fifo_write, o_out_last;
  logic [BW-1:0] o_data;

  merger_node_p #(.P(P), .DATA_WIDTH(DW), .KEY_WIDTH(DW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fifo_0        (i_fifo_0),
    .i_fifo_0_empty  (i_fifo_0_empty),
    .i_fifo_0_last   (i_fifo_0_last),
    .i_fifo_1        (i_fifo_1),
    .i_fifo_1_empty  (i_fifo_1_empty),
    .i_fifo_1_last   (i_fifo_1_last),
    .i_fifo_out_ready(i_fifo_out_ready),
    .o_fifo_0_read   (o_fifo_0_read),
    .o_fifo_1_read   (o_fifo_1_read),
    .o_out_fifo_write(o_out_fifo_write),
    .o_data          (o_data),
    .o_out_last      (o_out_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } batch_t;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] lo;
    logic [BW-1:0] hi;
    logic          first1;
  } vec_t;

  batch_t      q0[$], q1[$], exp_q[$];
  logic        exp_rd[$];
  logic [31:0] va[$], vb[$];
  vec_t        tbl[6];

  int checks = 0, errors = 0, cyc = 0, ready_mode = 0;
  int g0lo = 0, g0hi = 0, g1lo = 0, g1hi = 0;
  logic rnd_gap = 1'b0, prev_stall = 1'b0;

  function automatic logic [BW-1:0] mk(input logic [31:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic [BW:0] act, input logic [BW:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic drive();
    logic f0, f1;
    f0 = (cyc >= g0lo && cyc < g0hi) || (rnd_gap && $urandom_range(0, 4) == 0);
    f1 = (cyc >= g1lo && cyc < g1hi) || (rnd_gap && $urandom_range(0, 4) == 0);
    i_fifo_0 = '0; i_fifo_0_last = 1'b0;
    i_fifo_1 = '0; i_fifo_1_last = 1'b0;
    if (q0.size() != 0) begin i_fifo_0 = q0[0].data; i_fifo_0_last = q0[0].last; end
    if (q1.size() != 0) begin i_fifo_1 = q1[0].data; i_fifo_1_last = q1[0].last; end
    i_fifo_0_empty = (q0.size() == 0) || f0;
    i_fifo_1_empty = (q1.size() == 0) || f1;
    case (ready_mode)
      1:       i_fifo_out_ready = (cyc % 3 == 0);
      2:       i_fifo_out_ready = ($urandom_range(0, 3) != 0);
      default: i_fifo_out_ready = 1'b1;
    endcase
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); exp_q.delete(); exp_rd.delete();
    g0lo = 0; g0hi = 0; g1lo = 0; g1hi = 0;
    rnd_gap = 1'b0; ready_mode = 0; cyc = 0; prev_stall = 1'b0;
  endtask

  // Reference: output is the sorted union chunked into P; pops follow the
  // smaller-first-record rule over batch heads until one run is used up.
  task automatic add_pair();
    logic [31:0] all[$];
    batch_t      bt;
    int na, nb, ia, ib;
    na = va.size() / P;
    nb = vb.size() / P;
    for (int b = 0; b < na; b++) begin
      for (int k = 0; k < P; k++) bt.data[k*DW +: DW] = va[b*P+k];
      bt.last = (b == na - 1);
      q0.push_back(bt);
    end
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < P; k++) bt.data[k*DW +: DW] = vb[b*P+k];
      bt.last = (b == nb - 1);
      q1.push_back(bt);
    end
    all = va;
    foreach (vb[k]) all.push_back(vb[k]);
    all.sort();
    for (int b = 0; b < na + nb; b++) begin
      for (int k = 0; k < P; k++) bt.data[k*DW +: DW] = all[b*P+k];
      bt.last = (b == na + nb - 1);
      exp_q.push_back(bt);
    end
    ia = 0; ib = 0;
    while (ia < na && ib < nb) begin
      if (vb[ib*P] < va[ia*P]) begin exp_rd.push_back(1'b1); ib++; end
      else begin exp_rd.push_back(1'b0); ia++; end
    end
    while (ia < na) begin exp_rd.push_back(1'b0); ia++; end
    while (ib < nb) begin exp_rd.push_back(1'b1); ib++; end
  endtask

  task automatic load_basic();
    va.delete(); vb.delete();
    for (int k = 0; k < 8; k++) begin
      va.push_back(32'(2 * k + 1));
      vb.push_back(32'(2 * k + 2));
    end
    add_pair();
  endtask

  task automatic cycle();
    logic   r0, r1, rdy;
    batch_t e;
    @(negedge clk);
    r0  = o_fifo_0_read;
    r1  = o_fifo_1_read;
    rdy = i_fifo_out_ready;
    if (prev_stall) chk1("stall_no_write", o_out_fifo_write, 1'b0);
    if (o_out_fifo_write) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got write=1 data=%h required no write", o_data);
      end else begin
        e = exp_q.pop_front();
        chkb("out_batch", {o_out_last, o_data}, {e.last, e.data});
      end
    end
    if (r0 || r1) begin
      chk1("one_read", r0 && r1, 1'b0);
      chk1("read_needs_ready", rdy, 1'b1);
      chk1("read_not_empty", r0 ? i_fifo_0_empty : i_fifo_1_empty, 1'b0);
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got r0=%0b r1=%0b required none", r0, r1);
      end else begin
        chk1("read_order", r1, exp_rd.pop_front());
      end
    end
    prev_stall = !rdy;
    @(posedge clk);
    #1;
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    cyc++;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0 || exp_rd.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d batches %0d reads pending required 0", exp_q.size(), exp_rd.size());
    end
    repeat (3) cycle();
  endtask

  initial begin
    batch_t bt;

    tbl[0] = '{mk(1, 2, 3, 4), mk(0, 9, 9, 9), mk(0, 1, 2, 3), mk(4, 9, 9, 9), 1'b1};
    tbl[1] = '{mk(5, 5, 5, 5), mk(5, 5, 5, 5), mk(5, 5, 5, 5), mk(5, 5, 5, 5), 1'b0};
    tbl[2] = '{mk(1, 1, 8, 8), mk(2, 3, 4, 9), mk(1, 1, 2, 3), mk(4, 8, 8, 9), 1'b0};
    tbl[3] = '{mk(10, 20, 30, 40), mk(1, 2, 3, 4), mk(1, 2, 3, 4), mk(10, 20, 30, 40), 1'b1};
    tbl[4] = '{mk(0, 0, 0, 0), {BW{1'b1}}, mk(0, 0, 0, 0), {BW{1'b1}}, 1'b0};
    tbl[5] = '{{BW{1'b1}}, mk(7, 8, 9, 10), mk(7, 8, 9, 10), {BW{1'b1}}, 1'b1};

    rst = 1'b1;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #2;
    chk1("reset_write", o_out_fifo_write, 1'b0);
    chk1("reset_last", o_out_last, 1'b0);
    chkb("reset_data", {1'b0, o_data}, '0);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      clear_all();
      bt.last = 1'b1;
      bt.data = tbl[t].a; q0.push_back(bt);
      bt.data = tbl[t].b; q1.push_back(bt);
      bt.data = tbl[t].lo; bt.last = 1'b0; exp_q.push_back(bt);
      bt.data = tbl[t].hi; bt.last = 1'b1; exp_q.push_back(bt);
      exp_rd.push_back(tbl[t].first1);
      exp_rd.push_back(!tbl[t].first1);
      drive();
      run_until_done(50);
    end

    clear_all();
    load_basic();
    drive();
    run_until_done(50);

    clear_all();
    ready_mode = 1;
    load_basic();
    drive();
    run_until_done(100);

    // gap on input 1 while in MERGE, then input 0 (next run queued) hidden during DRAIN_1
    clear_all();
    load_basic();
    va.delete(); vb.delete();
    for (int k = 0; k < P; k++) begin va.push_back(32'd5); vb.push_back(32'd5); end
    add_pair();
    g1lo = 1; g1hi = 4; g0lo = 6; g0hi = 8;
    drive();
    run_until_done(100);

    // async reset asserted off-edge while DRAIN_1 holds a pending write
    clear_all();
    load_basic();
    drive();
    repeat (3) cycle();
    #1;
    rst = 1'b1;
    #1;
    chk1("async_rst_write", o_out_fifo_write, 1'b0);
    chk1("async_rst_last", o_out_last, 1'b0);
    chkb("async_rst_data", {1'b0, o_data}, '0);
    @(posedge clk);
    #2;
    clear_all();
    load_basic();
    drive();
    rst = 1'b0;
    run_until_done(50);

    clear_all();
    ready_mode = 2;
    rnd_gap = 1'b1;
    for (int pr = 0; pr < 20; pr++) begin
      int na, nb;
      va.delete(); vb.delete();
      na = $urandom_range(1, 4);
      nb = $urandom_range(1, 4);
      for (int k = 0; k < na * P; k++)
        va.push_back(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 40)));
      for (int k = 0; k < nb * P; k++)
        vb.push_back(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 40)));
      va.sort();
      vb.sort();
      add_pair();
    end
    drive();
    run_until_done(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
